// File: rtl/accum_pkg.sv
// rtl/accum_pkg.sv - shared widths, channel-width rule and saturate/wrap adder for accum_mc
package accum_pkg;

    localparam int DIN_W_DEF  = 8;
    localparam int DOUT_W_DEF = 16;
    localparam int CALC_W     = 64;

    typedef struct packed {
        logic               ovf;
        logic signed [CALC_W-1:0] val;
    } add_res_t;

    function automatic int ch_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Sum is formed wide; the result is clamped or wrapped back into dout_w signed bits.
    function automatic add_res_t sat_add(input logic signed [CALC_W-1:0] acc,
                                         input logic signed [CALC_W-1:0] din,
                                         input int                       dout_w,
                                         input logic                     sat);
        logic signed [CALC_W-1:0] sum;
        logic signed [CALC_W-1:0] max_v;
        logic signed [CALC_W-1:0] min_v;
        add_res_t                 r;
        sum   = acc + din;
        max_v = (64'sd1 <<< (dout_w - 1)) - 64'sd1;
        min_v = -max_v - 64'sd1;
        r.ovf = (sum > max_v) || (sum < min_v);
        if (!r.ovf)
            r.val = sum;
        else if (sat)
            r.val = (sum > max_v) ? max_v : min_v;
        else
            r.val = (sum <<< (CALC_W - dout_w)) >>> (CALC_W - dout_w);
        return r;
    endfunction

endpackage

// File: rtl/accum_lane.sv
// rtl/accum_lane.sv - one accumulator channel with sticky overflow and clear-then-load
module accum_lane
    import accum_pkg::*;
#(
    parameter int DIN_W  = DIN_W_DEF,
    parameter int DOUT_W = DOUT_W_DEF,
    parameter bit SAT    = 1'b1
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_add_en,
    input  logic                     i_clr,
    input  logic signed [DIN_W-1:0]  i_din,
    output logic signed [DOUT_W-1:0] o_acc,
    output logic                     o_ovf
);

    logic signed [DOUT_W-1:0] r_acc;
    logic                     r_ovf;
    add_res_t                 w_res;
    logic signed [DOUT_W-1:0] w_din_sext;
    logic                     w_unused_hi;

    assign w_din_sext = {{(DOUT_W-DIN_W){i_din[DIN_W-1]}}, i_din};

    always_comb begin
        w_res = sat_add({{(CALC_W-DOUT_W){r_acc[DOUT_W-1]}}, r_acc},
                        {{(CALC_W-DIN_W){i_din[DIN_W-1]}}, i_din},
                        DOUT_W, SAT);
    end

    assign w_unused_hi = ^w_res.val[CALC_W-1:DOUT_W];

    // A clear coinciding with a sample loads the sample; one sample can never overflow.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
        end else if (i_clr) begin
            r_acc <= i_add_en ? w_din_sext : '0;
            r_ovf <= 1'b0;
        end else if (i_add_en) begin
            r_acc <= w_res.val[DOUT_W-1:0];
            if (w_res.ovf)
                r_ovf <= 1'b1;
        end
    end

    assign o_acc = r_acc;
    assign o_ovf = r_ovf;

endmodule

// File: rtl/accum_mc.sv
// rtl/accum_mc.sv - multi-channel signed accumulator: channel decode and registered read-out
module accum_mc
    import accum_pkg::*;
#(
    parameter int DIN_W  = DIN_W_DEF,
    parameter int DOUT_W = DOUT_W_DEF,
    parameter int NCH    = 4,
    parameter int SAT    = 1,
    localparam int CH_W  = ch_width(NCH)
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_din_en,
    input  logic [CH_W-1:0]          i_din_ch,
    input  logic signed [DIN_W-1:0]  i_din,
    input  logic                     i_clr_en,
    input  logic [CH_W-1:0]          i_clr_ch,
    input  logic                     i_rd_en,
    input  logic [CH_W-1:0]          i_rd_ch,
    input  logic                     i_rd_clr,
    output logic signed [DOUT_W-1:0] o_dout,
    output logic                     o_dout_vld,
    output logic [NCH-1:0]           o_ovf
);

    logic signed [DOUT_W-1:0] w_acc [NCH];
    logic [NCH-1:0]           w_add;
    logic [NCH-1:0]           w_clr;
    logic signed [DOUT_W-1:0] w_rd_data;
    logic signed [DOUT_W-1:0] r_dout;
    logic                     r_dout_vld;

    // Indices >= NCH match no lane, so writes and clears to them fall away.
    for (genvar g = 0; g < NCH; g++) begin : g_lane
        assign w_add[g] = i_din_en && (i_din_ch == CH_W'(g));
        assign w_clr[g] = (i_clr_en && (i_clr_ch == CH_W'(g)))
                       || (i_rd_en && i_rd_clr && (i_rd_ch == CH_W'(g)));

        accum_lane #(
            .DIN_W  (DIN_W),
            .DOUT_W (DOUT_W),
            .SAT    (SAT != 0)
        ) u_lane (
            .i_clk    (i_clk),
            .i_rst    (i_rst),
            .i_add_en (w_add[g]),
            .i_clr    (w_clr[g]),
            .i_din    (i_din),
            .o_acc    (w_acc[g]),
            .o_ovf    (o_ovf[g])
        );
    end

    always_comb begin
        w_rd_data = '0;
        for (int i = 0; i < NCH; i++) begin
            if (i_rd_ch == CH_W'(i))
                w_rd_data = w_acc[i];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_dout     <= '0;
            r_dout_vld <= 1'b0;
        end else begin
            r_dout_vld <= i_rd_en;
            if (i_rd_en)
                r_dout <= w_rd_data;
        end
    end

    assign o_dout     = r_dout;
    assign o_dout_vld = r_dout_vld;

endmodule

// File: tb/tb_accum_mc.sv
// tb/tb_accum_mc.sv - randomized + directed check of accum_mc against a behavioural model
module tb_accum_mc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst = 1'b1;
    logic              din_en = 1'b0;
    logic [1:0]        din_ch = '0;
    logic signed [7:0] din = '0;
    logic              clr_en = 1'b0;
    logic [1:0]        clr_ch = '0;
    logic              rd_en = 1'b0;
    logic [1:0]        rd_ch = '0;
    logic              rd_clr = 1'b0;

    logic signed [15:0] dout_s, dout_w, dout_o;
    logic               vld_s, vld_w, vld_o;
    logic [3:0]         ovf_s, ovf_w;
    logic [2:0]         ovf_o;

    accum_mc #(.DIN_W(8), .DOUT_W(16), .NCH(4), .SAT(1)) u_sat (
        .i_clk(clk), .i_rst(rst), .i_din_en(din_en), .i_din_ch(din_ch), .i_din(din),
        .i_clr_en(clr_en), .i_clr_ch(clr_ch), .i_rd_en(rd_en), .i_rd_ch(rd_ch),
        .i_rd_clr(rd_clr), .o_dout(dout_s), .o_dout_vld(vld_s), .o_ovf(ovf_s));

    accum_mc #(.DIN_W(8), .DOUT_W(16), .NCH(4), .SAT(0)) u_wrap (
        .i_clk(clk), .i_rst(rst), .i_din_en(din_en), .i_din_ch(din_ch), .i_din(din),
        .i_clr_en(clr_en), .i_clr_ch(clr_ch), .i_rd_en(rd_en), .i_rd_ch(rd_ch),
        .i_rd_clr(rd_clr), .o_dout(dout_w), .o_dout_vld(vld_w), .o_ovf(ovf_w));

    accum_mc #(.DIN_W(8), .DOUT_W(16), .NCH(3), .SAT(1)) u_odd (
        .i_clk(clk), .i_rst(rst), .i_din_en(din_en), .i_din_ch(din_ch), .i_din(din),
        .i_clr_en(clr_en), .i_clr_ch(clr_ch), .i_rd_en(rd_en), .i_rd_ch(rd_ch),
        .i_rd_clr(rd_clr), .o_dout(dout_o), .o_dout_vld(vld_o), .o_ovf(ovf_o));

    int total = 0;
    int bad   = 0;

    // Behavioural model: per instance, per channel integer accumulator and sticky flag.
    int nch_of [3] = '{4, 4, 3};
    int sat_of [3] = '{1, 0, 1};
    int macc   [3][4];
    bit movf   [3][4];
    int edout  [3];
    bit evld   [3];
    bit chk_on = 1'b0;

    initial begin
        for (int k = 0; k < 3; k++) begin
            edout[k] = 0;
            evld[k]  = 0;
            for (int c = 0; c < 4; c++) begin
                macc[k][c] = 0;
                movf[k][c] = 0;
            end
        end
    end

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                evld[k]  = 0;
                edout[k] = 0;
                for (int c = 0; c < 4; c++) begin
                    macc[k][c] = 0;
                    movf[k][c] = 0;
                end
            end else begin
                evld[k] = rd_en;
                if (rd_en)
                    edout[k] = (int'(rd_ch) < nch_of[k]) ? macc[k][rd_ch] : 0;
                for (int c = 0; c < nch_of[k]; c++) begin
                    bit is_clr, is_add;
                    int s;
                    is_clr = (clr_en && int'(clr_ch) == c) || (rd_en && rd_clr && int'(rd_ch) == c);
                    is_add = din_en && int'(din_ch) == c;
                    if (is_clr) begin
                        macc[k][c] = is_add ? int'(din) : 0;
                        movf[k][c] = 0;
                    end else if (is_add) begin
                        s = macc[k][c] + int'(din);
                        if (s > 32767 || s < -32768) begin
                            movf[k][c] = 1;
                            if (sat_of[k] != 0)
                                s = (s > 32767) ? 32767 : -32768;
                            else if (s > 32767)
                                s = s - 65536;
                            else
                                s = s + 65536;
                        end
                        macc[k][c] = s;
                    end
                end
            end
        end
    end

    function automatic logic [3:0] exp_ovf(input int k);
        logic [3:0] v;
        v = '0;
        for (int c = 0; c < nch_of[k]; c++)
            v[c] = movf[k][c];
        return v;
    endfunction

    always @(negedge clk) begin
        if (chk_on) begin
            logic signed [15:0] d [3];
            logic               v [3];
            logic [3:0]         o [3];
            d[0] = dout_s; d[1] = dout_w; d[2] = dout_o;
            v[0] = vld_s;  v[1] = vld_w;  v[2] = vld_o;
            o[0] = ovf_s;  o[1] = ovf_w;  o[2] = {1'b0, ovf_o};
            for (int k = 0; k < 3; k++) begin
                total++;
                if (v[k] !== evld[k]) begin
                    bad++;
                    $display("FAIL vld inst%0d t=%0t got=%b want=%b", k, $time, v[k], evld[k]);
                end
                total++;
                if (int'(d[k]) != edout[k] || $isunknown(d[k])) begin
                    bad++;
                    $display("FAIL dout inst%0d t=%0t got=%0d want=%0d", k, $time, d[k], edout[k]);
                end
                total++;
                if (o[k] !== exp_ovf(k)) begin
                    bad++;
                    $display("FAIL ovf inst%0d t=%0t got=%b want=%b", k, $time, o[k], exp_ovf(k));
                end
            end
        end
    end

    task automatic lit(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        din_en = 0; clr_en = 0; rd_en = 0; rd_clr = 0; rst = 0;
    endtask

    task automatic write(input logic [1:0] ch, input logic signed [7:0] v);
        idle();
        din_en = 1; din_ch = ch; din = v;
        tick();
    endtask

    task automatic read(input logic [1:0] ch);
        idle();
        rd_en = 1; rd_ch = ch;
        tick();
        idle();
    endtask

    initial begin
        rst = 1;
        tick();
        tick();
        chk_on = 1;
        lit("reset_dout", dout_s, 0);
        lit("reset_vld", vld_s, 0);
        lit("reset_ovf", ovf_s, 0);

        write(2'd0, 8'sd5);
        write(2'd0, -8'sd3);
        read(2'd0);
        lit("rd0_dout", dout_s, 2);
        lit("rd0_vld", vld_s, 1);
        lit("rd0_ovf", ovf_s, 0);
        tick();
        lit("rd0_vld_drop", vld_s, 0);
        lit("rd0_dout_hold", dout_s, 2);

        for (int i = 0; i < 258; i++) write(2'd1, 8'sd127);
        write(2'd1, 8'sd127);
        read(2'd1);
        lit("sat_max", dout_s, 32767);
        lit("sat_ovf1", ovf_s[1], 1);
        lit("wrap_val", dout_w, -32643);
        lit("wrap_ovf1", ovf_w[1], 1);
        write(2'd1, -8'sd128);
        read(2'd1);
        lit("sat_after_neg", dout_s, 32639);
        lit("sat_ovf1_sticky", ovf_s[1], 1);
        read(2'd0);
        lit("wrap_ch0_untouched", dout_w, 2);

        for (int i = 0; i < 259; i++) write(2'd2, 8'sd127);
        for (int i = 0; i < 255; i++) write(2'd2, -8'sd128);
        write(2'd2, -8'sd77);
        read(2'd2);
        lit("ch2_at50", dout_s, 50);
        lit("ch2_ovf_set", ovf_s[2], 1);
        idle();
        din_en = 1; din_ch = 2'd2; din = 8'sd10; clr_en = 1; clr_ch = 2'd2;
        tick();
        read(2'd2);
        lit("ch2_clr_load", dout_s, 10);
        lit("ch2_ovf_clr", ovf_s[2], 0);

        write(2'd3, -8'sd7);
        idle();
        rd_en = 1; rd_ch = 2'd3; rd_clr = 1; din_en = 1; din_ch = 2'd3; din = 8'sd4;
        tick();
        idle();
        lit("ch3_rdclr_pre", dout_s, -7);
        lit("odd_oob_dout", dout_o, 0);
        lit("odd_oob_vld", vld_o, 1);
        read(2'd3);
        lit("ch3_after_load", dout_s, 4);

        idle();
        din_en = 1; din_ch = 2'd0; din = 8'sd9; clr_en = 1; clr_ch = 2'd0;
        tick();
        idle();
        rst = 1; rd_en = 1; rd_ch = 2'd0;
        tick();
        idle();
        lit("rst_rd_vld", vld_s, 0);
        lit("rst_rd_dout", dout_s, 0);
        lit("rst_ovf", ovf_s, 0);

        for (int i = 0; i < 3000; i++) begin
            rst    = ($urandom_range(0, 199) == 0);
            din_en = 1'($urandom);
            din_ch = 2'($urandom);
            din    = ($urandom_range(0, 2) == 0) ? 8'($urandom) : (1'($urandom) ? 8'sd127 : -8'sd128);
            clr_en = ($urandom_range(0, 31) == 0);
            clr_ch = 2'($urandom);
            rd_en  = 1'($urandom);
            rd_ch  = 2'($urandom);
            rd_clr = ($urandom_range(0, 7) == 0);
            tick();
        end
        idle();
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/accum_mc.md
Name: accum_mc

Overview:
- Parametrised multi-channel signed accumulator; successor to the single-channel 8-in/16-out accum.
- NCH independent accumulators share one input port, selected per sample by channel index.
- Adds wrap or saturate overflow mode, per-channel sticky overflow flags, per-channel clear, and registered read-out with optional read-and-clear.
- Sits between the sample source and the DPI-driven test/readout logic.

Parameters:
- DIN_W, 8: signed input sample width.
- DOUT_W, 16: signed accumulator/output width; must satisfy DOUT_W > DIN_W.
- NCH, 4: number of channels, 1..16.
- SAT, 1: 1 = saturate on overflow; 0 = two's-complement wrap.
- CH_W, $clog2(NCH) with minimum 1 (derived, localparam): channel index width.

Ports:
- clk, in, 1: clock; all logic on posedge.
- rst, in, 1: synchronous active-high reset.
- din_en, in, 1: accumulate din into channel din_ch this cycle.
- din_ch, in, CH_W: target channel for din.
- din, in, DIN_W signed: input sample.
- clr_en, in, 1: clear channel clr_ch this cycle.
- clr_ch, in, CH_W: channel to clear.
- rd_en, in, 1: read request.
- rd_ch, in, CH_W: channel to read.
- rd_clr, in, 1: qualifies rd_en; clears rd_ch after capture.
- dout, out, DOUT_W signed: read data.
- dout_vld, out, 1: dout valid strobe.
- ovf, out, NCH: sticky per-channel overflow flags.

Behaviour:
- Reset: all acc[i]=0, dout=0, dout_vld=0, ovf=0. rst overrides every other input in the same cycle; a pending read is lost (dout_vld=0 the following cycle).
- Accumulate: when din_en=1 at edge N, acc[din_ch] becomes acc[din_ch] + sext(din) after edge N. The sum is formed at DOUT_W+1 bits.
  - Overflow = sum outside [-2^(DOUT_W-1), 2^(DOUT_W-1)-1].
  - On overflow: SAT=1 clamps to max or min; SAT=0 keeps the low DOUT_W bits.
  - Either way, ovf[din_ch] is set and stays set.
- Read: rd_en=1 at edge N captures the pre-update value acc[rd_ch] (the state before edge N's update) into dout. dout_vld=1 for exactly the cycle following edge N.
  - A din_en to the same channel at edge N is not reflected in dout.
  - dout holds its value when dout_vld=0.
  - Back-to-back reads allowed, one per cycle.
- Clear: clr_en=1, or rd_en&rd_clr, sets the target channel's acc=0 and ovf bit=0.
- Same-channel conflicts: if a clear and din_en hit the same channel in one cycle, the result is acc = sext(din) (clear-then-load). ovf stays 0, since a single sample cannot overflow.
- clr_ch and rd_ch with rd_clr may name different channels; both clears apply.
- Different channels update independently in the same cycle.
- Out-of-range index (>= NCH, possible only when NCH is not a power of 2):
  - din_en or clear to such an index is ignored.
  - rd_en returns dout=0 with dout_vld=1.
- rd_clr without rd_en has no effect.
- Latency: accumulate 1 cycle; read 1 cycle.

Decomposition:
- Package accum_pkg holds:
  - the function computing the saturate/wrap result and overflow flag from (acc, din, SAT);
  - the derived channel-width rule;
  - defaults DIN_W=8, DOUT_W=16.
- Sub-module accum_lane: one channel's register, adder, saturation, ovf flag and clear-then-load priority. Instantiated NCH times in a generate loop.
- The top level does channel decode and the registered read mux.

Test Plan:
- Reset, then din_en ch0 with +5, then -3, then rd_en ch0 on the next cycle -> dout=2, dout_vld high for 1 cycle, ovf=0.
- SAT=1: 258 writes of +127 to ch1 (acc=32766), then one more +127 -> acc=32767, ovf[1]=1. Then -128 -> acc=32639, ovf[1] still 1.
- SAT=0: ch1 at 32766 plus +127 -> acc=-32643, ovf[1]=1. Other channels unchanged.
- ch2 at 50 with ovf[2]=1; in one cycle assert din_en ch2 din=10 and clr_en ch2 -> acc[2]=10, ovf[2]=0.
- ch3 at -7; in one cycle assert rd_en, rd_clr, rd_ch=3 and din_en ch3 din=4 -> dout=-7 next cycle, acc[3]=4. Follow-up read -> 4.
- NCH=3: din_en ch3 ignored; rd_en ch3 -> dout=0, vld=1. Then rst asserted in the same cycle as rd_en ch0 (acc=9) -> dout_vld=0, all acc=0, ovf=0.
